// File: rtl/keypad_pkg.sv
// Shared keypad definitions: scan FSM states, the 4x4 key map and the
// row priority encoder used by the scanner and the debouncer bench.
package keypad_pkg;

  typedef enum logic {S_SCAN, S_HOLD} scan_state_t;

  // KEYMAP[row][col]
  localparam logic [3:0] KEYMAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // Index of the lowest-numbered row that is pulled low.
  function automatic logic [1:0] row_priority(input logic [3:0] rows_n);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows_n[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix pins plus the decoded key outputs handed to the debouncer.
interface keypad_scanner_if;
  logic [3:0] rows_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_pressed;

  modport master (input rows_n, output col_n, output key_code, output key_pressed);
  modport slave  (output rows_n, input col_n, input key_code, input key_pressed);
endinterface

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs with a settable reset value.
module sync_2ff #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_p0;
  logic [WIDTH-1:0] sync_p1;

  // p0: metastability catcher, p1: settled output
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_p0 <= RESET_VAL;
      sync_p1 <= RESET_VAL;
    end else begin
      meta_p0 <= d;
      sync_p1 <= meta_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks an active-low column, latches the first
// key seen and holds it until that key's row releases. No debouncing here.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 48000
) (
  input  logic              clk,
  input  logic              reset,
  keypad_scanner_if.master  kp
);

  localparam int                CNT_W      = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(SCAN_DIV - 1);

  scan_state_t      state;
  scan_state_t      state_next;
  logic [3:0]       rows_s;
  logic [CNT_W-1:0] dwell;
  logic [1:0]       col_idx;
  logic [1:0]       row_lat;
  logic [3:0]       key_code;
  logic             key_pressed;
  logic             dwell_end;
  logic             any_low;
  logic             latched_high;
  logic             advance_col;
  logic             latch_key;
  logic             release_key;

  sync_2ff #(.WIDTH(4), .RESET_VAL(4'hF)) u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (kp.rows_n),
    .q     (rows_s)
  );

  assign dwell_end    = (dwell == DWELL_LAST);
  assign any_low      = (rows_s != 4'hF);
  assign latched_high = rows_s[row_lat];

  always_ff @(posedge clk) begin
    if (reset) state <= S_SCAN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_SCAN:  if (dwell_end && any_low)      state_next = S_HOLD;
      S_HOLD:  if (dwell_end && latched_high) state_next = S_SCAN;
      default: state_next = S_SCAN;
    endcase
  end

  always_comb begin
    latch_key   = 1'b0;
    release_key = 1'b0;
    advance_col = 1'b0;
    case (state)
      S_SCAN: begin
        latch_key   = dwell_end && any_low;
        advance_col = dwell_end && !any_low;
      end
      S_HOLD: begin
        release_key = dwell_end && latched_high;
        advance_col = dwell_end && latched_high;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dwell       <= '0;
      col_idx     <= 2'd0;
      key_code    <= 4'h0;
      key_pressed <= 1'b0;
    end else begin
      dwell <= dwell_end ? '0 : dwell + 1'b1;
      if (advance_col) col_idx <= col_idx + 2'd1;
      if (latch_key) begin
        key_code    <= KEYMAP[row_priority(rows_s)][col_idx];
        key_pressed <= 1'b1;
      end else if (release_key) begin
        key_pressed <= 1'b0;
      end
    end
  end

  // Row index is only meaningful while holding, so it carries no reset.
  always_ff @(posedge clk) begin
    if (latch_key) row_lat <= row_priority(rows_s);
  end

  assign kp.col_n       = ~(4'b0001 << col_idx);
  assign kp.key_code    = key_code;
  assign kp.key_pressed = key_pressed;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a switch-matrix model drives rows_n from the held
// keys and the driven column; a cycle-level reference tracks expected outputs.
module tb_keypad_scanner;
  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] held = '0;
  logic [3:0]  rows_drv;
  int          errors = 0;
  int          checks = 0;

  keypad_scanner_if kp ();

  keypad_scanner #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp)
  );

  always #5 clk = ~clk;

  // Switch matrix: a held key connects its row to its column.
  always_comb begin
    rows_drv = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (held[r*4+c] && !kp.col_n[c]) rows_drv[r] = 1'b0;
  end
  assign kp.rows_n = rows_drv;

  // Reference model
  int          keymap_tb [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
  int          m_dwell = 0, m_col = 0, m_row = 0, m_code = 0, m_r = 0;
  bit          m_pressed = 0, m_hold = 0;
  logic [3:0]  m_s1 = 4'hF, m_s2 = 4'hF, m_rs;

  always @(posedge clk) begin
    m_rs = m_s2;
    if (reset) begin
      m_dwell = 0; m_col = 0; m_code = 0; m_pressed = 0; m_hold = 0;
      m_s1 = 4'hF; m_s2 = 4'hF;
    end else begin
      if (m_dwell == SCAN_DIV - 1) begin
        if (!m_hold) begin
          if (m_rs != 4'hF) begin
            m_r = 0;
            while (m_rs[m_r]) m_r++;
            m_row = m_r;
            m_code = keymap_tb[m_r*4 + m_col];
            m_pressed = 1; m_hold = 1;
          end else begin
            m_col = (m_col + 1) % 4;
          end
        end else if (m_rs[m_row]) begin
          m_pressed = 0; m_hold = 0;
          m_col = (m_col + 1) % 4;
        end
      end
      m_dwell = (m_dwell + 1) % SCAN_DIV;
      m_s2 = m_s1;
      m_s1 = kp.rows_n;
    end
  end

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (kp.col_n !== 4'b1110 || kp.key_code !== 4'h0 || kp.key_pressed !== 1'b0) begin
        errors++;
        $display("FAIL reset cyc%0d: col_n=%b code=%h pressed=%b, want 1110 0 0",
                 i, kp.col_n, kp.key_code, kp.key_pressed);
      end
    end
  endtask

  task automatic test_idle_scan();
    logic [3:0] exp_col;
    reset = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      exp_col = ~(4'b0001 << ((i / 4) % 4));
      checks++;
      if (kp.col_n !== exp_col || kp.key_pressed !== 1'b0) begin
        errors++;
        $display("FAIL idle_scan cyc%0d: col_n=%b pressed=%b, want %b 0",
                 i, kp.col_n, kp.key_pressed, exp_col);
      end
    end
  endtask

  task automatic test_hold_key();
    int n;
    held = 16'h0040;
    n = 0;
    while (!kp.key_pressed && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (kp.key_pressed !== 1'b1 || kp.key_code !== 4'h6) begin
      errors++;
      $display("FAIL hold_detect: pressed=%b code=%h, want 1 6", kp.key_pressed, kp.key_code);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (kp.col_n !== 4'b1011 || kp.key_pressed !== 1'b1) begin
        errors++;
        $display("FAIL hold_frozen cyc%0d: col_n=%b pressed=%b, want 1011 1",
                 i, kp.col_n, kp.key_pressed);
      end
    end
  endtask

  task automatic test_first_key_wins();
    int n;
    held = held | 16'h1000;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (kp.key_code !== 4'h6 || kp.key_pressed !== 1'b1) begin
        errors++;
        $display("FAIL first_wins cyc%0d: code=%h pressed=%b, want 6 1",
                 i, kp.key_code, kp.key_pressed);
      end
    end
    held = held & ~16'h0040;
    n = 0;
    while (kp.key_pressed && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (kp.key_pressed !== 1'b0 || n > 6 || kp.col_n !== 4'b0111) begin
      errors++;
      $display("FAIL release_12: pressed=%b after %0d cyc col_n=%b, want 0 within 6 col 0111",
               kp.key_pressed, n, kp.col_n);
    end
    held = '0;
    n = 0;
    while (kp.key_pressed && n < 20) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_multi_row();
    int n;
    held = 16'h0101;
    n = 0;
    while (!kp.key_pressed && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (kp.key_pressed !== 1'b1 || kp.key_code !== 4'h1) begin
      errors++;
      $display("FAIL multi_row: pressed=%b code=%h, want 1 1", kp.key_pressed, kp.key_code);
    end
    held = '0;
    n = 0;
    while (kp.key_pressed && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (kp.key_pressed !== 1'b0 || kp.key_code !== 4'h1) begin
      errors++;
      $display("FAIL multi_release: pressed=%b code=%h, want 0 1 (code held)",
               kp.key_pressed, kp.key_code);
    end
    held = 16'h8000;
    n = 0;
    while (!kp.key_pressed && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (kp.key_pressed !== 1'b1 || kp.key_code !== 4'hD) begin
      errors++;
      $display("FAIL key_33: pressed=%b code=%h, want 1 d", kp.key_pressed, kp.key_code);
    end
    held = '0;
    n = 0;
    while (kp.key_pressed && n < 10) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset_in_hold();
    int n;
    held = 16'h0200;
    n = 0;
    while (!kp.key_pressed && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (kp.key_pressed !== 1'b1 || kp.key_code !== 4'h8) begin
      errors++;
      $display("FAIL pre_reset_hold: pressed=%b code=%h, want 1 8", kp.key_pressed, kp.key_code);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (kp.key_pressed !== 1'b0 || kp.key_code !== 4'h0 || kp.col_n !== 4'b1110) begin
      errors++;
      $display("FAIL reset_in_hold: pressed=%b code=%h col_n=%b, want 0 0 1110",
               kp.key_pressed, kp.key_code, kp.col_n);
    end
    reset = 1'b0;
    n = 0;
    while (!kp.key_pressed && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (kp.key_pressed !== 1'b1 || kp.key_code !== 4'h8) begin
      errors++;
      $display("FAIL redetect_21: pressed=%b code=%h, want 1 8", kp.key_pressed, kp.key_code);
    end
    held = '0;
    n = 0;
    while (kp.key_pressed && n < 10) begin @(negedge clk); n++; end
  endtask

  task automatic test_random();
    logic [3:0] exp_col;
    int         kind, cycles;
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 3);
      held = '0;
      if (kind >= 1) held[$urandom_range(0, 15)] = 1'b1;
      if (kind == 3) held[$urandom_range(0, 15)] = 1'b1;
      reset = ($urandom_range(0, 9) == 0);
      cycles = $urandom_range(3, 40);
      for (int c = 0; c < cycles; c++) begin
        @(negedge clk);
        if (c == 0) reset = 1'b0;
        exp_col = ~(4'b0001 << m_col);
        checks++;
        if (kp.col_n !== exp_col || kp.key_code !== 4'(m_code) || kp.key_pressed !== m_pressed) begin
          errors++;
          $display("FAIL random it%0d cyc%0d: col_n=%b code=%h pressed=%b, want %b %h %b",
                   it, c, kp.col_n, kp.key_code, kp.key_pressed, exp_col, 4'(m_code), m_pressed);
        end
      end
    end
    held = '0;
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_hold_key();
    test_first_key_wins();
    test_multi_row();
    test_reset_in_hold();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
